// File: rtl/uart_arbiter.sv
// uart_arbiter: shares one uart_manage between N requesters using round-robin
// selection, with a per-requester lock for uninterrupted back-to-back transfers.
module uart_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req_order,
  input  logic [N-1:0]    req_lock,
  input  logic [2*N-1:0]  req_size,
  input  logic [N-1:0]    req_write_flag,
  input  logic [32*N-1:0] req_write_data,
  output logic [N-1:0]    req_accepted,
  output logic [N-1:0]    req_done,
  output logic [32*N-1:0] req_read_data,
  output logic [IW-1:0]   grant,
  output logic            busy,
  output logic            m_order,
  output logic [1:0]      m_size,
  output logic            m_write_flag,
  output logic [31:0]     m_write_data,
  input  logic            m_accepted,
  input  logic            m_done,
  input  logic [31:0]     m_read_data
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [IW-1:0] LAST   = IW'(N - 1);

  logic [1:0]    r_state;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] r_ptr;
  logic [31:0]   r_rdReg [N];

  logic [IW-1:0] w_winner;
  logic [IW-1:0] w_sel;
  logic [IW-1:0] w_nextPtr;
  logic          w_found;
  logic          w_order;
  logic          w_take;

  // Round-robin scan starting at the pointer, wrapping modulo N.
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = r_ptr;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && req_order[idx]) begin
        w_found  = 1'b1;
        w_winner = IW'(idx);
      end
    end
  end

  assign w_sel     = (r_state == ST_IDLE && w_found) ? w_winner : r_grant;
  assign w_nextPtr = (r_grant == LAST) ? '0 : r_grant + IW'(1);

  // Order is gated by rstn so outputs sit at their reset values while reset is held.
  always_comb begin
    w_order = 1'b0;
    case (r_state)
      ST_IDLE:   w_order = w_found;
      ST_LOCKED: w_order = req_order[r_grant];
      default:   w_order = 1'b0;
    endcase
    w_order = w_order & rstn;
  end

  assign w_take       = w_order & m_accepted;
  assign m_order      = w_order;
  assign m_size       = req_size[{w_sel, 1'b0} +: 2];
  assign m_write_flag = req_write_flag[w_sel];
  assign m_write_data = req_write_data[{w_sel, 5'b0} +: 32];
  assign grant        = r_grant;
  assign busy         = (r_state == ST_BUSY);

  always_comb begin
    req_accepted = '0;
    req_done     = '0;
    if (w_take) req_accepted[w_sel] = 1'b1;
    if (r_state == ST_BUSY && m_done) req_done[r_grant] = 1'b1;
  end

  // The done cycle forwards the live result; the register holds it afterwards.
  always_comb begin
    req_read_data = '0;
    for (int i = 0; i < N; i++) begin
      req_read_data[32*i +: 32] = req_done[i] ? m_read_data : r_rdReg[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      for (int i = 0; i < N; i++) r_rdReg[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_grant <= w_winner;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (m_done) begin
            r_rdReg[r_grant] <= m_read_data;
            if (req_lock[r_grant]) begin
              r_state <= ST_LOCKED;
            end else begin
              r_state <= ST_IDLE;
              r_ptr   <= w_nextPtr;
            end
          end
        end
        ST_LOCKED: begin
          if (w_take) begin
            r_state <= ST_BUSY;
          end else if (!req_lock[r_grant] && !req_order[r_grant]) begin
            r_state <= ST_IDLE;
            r_ptr   <= w_nextPtr;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
